// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - register offsets, CTRL bit positions and state type for the perf counter unit
package perf_pkg;

  localparam logic [31:0] OFF_CTRL       = 32'h00;
  localparam logic [31:0] OFF_STATUS     = 32'h04;
  localparam logic [31:0] OFF_CYCLE_LO   = 32'h08;
  localparam logic [31:0] OFF_CYCLE_HI   = 32'h0C;
  localparam logic [31:0] OFF_INSTRET_LO = 32'h10;
  localparam logic [31:0] OFF_INSTRET_HI = 32'h14;
  localparam logic [31:0] OFF_BRANCH     = 32'h18;
  localparam logic [31:0] OFF_MISPRED    = 32'h1C;
  localparam logic [31:0] OFF_STALL      = 32'h20;
  localparam logic [31:0] OFF_FLUSH      = 32'h24;
  localparam logic [31:0] OFF_DONE       = 32'h28;
  localparam logic [31:0] WINDOW_BYTES   = 32'd44;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } perf_state_t;

endpackage

// File: rtl/perf_ctr.sv
// rtl/perf_ctr.sv - single event counter with optional saturation at all-ones
module perf_ctr #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);

  logic [WIDTH-1:0] cnt_q;
  logic             at_max;

  assign at_max = &cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt_q <= '0;
    end else if (en && inc && !(SATURATE && at_max)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;
  // Non-saturating counters wrap, so reaching all-ones is not a sticky condition for them.
  assign sat = SATURATE ? at_max : 1'b0;

endmodule

// File: rtl/perf_counter_mmio.sv
// rtl/perf_counter_mmio.sv - memory-mapped pipeline performance counters on the data bus
module perf_counter_mmio
  import perf_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_4000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic        re_i,
  output logic [31:0] rdata_o,
  output logic        hit_o,
  input  logic        instret_i,
  input  logic        branch_e_i,
  input  logic        flush_d_i,
  input  logic        flush_e_i,
  input  logic        stall_f_i,
  output logic        done_o
);

  perf_state_t state, state_nxt;
  logic [31:0] off;
  logic        wr, ctrl_wr, done_wr, clr, run;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [31:0] branch_cnt, mispred_cnt, stall_cnt, flush_cnt;
  logic [5:0]  sat_vec;
  logic        sat_any;
  logic [31:0] cycle_hi_snap, instret_hi_snap;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  // Addresses below BASE wrap to huge offsets, so one compare covers both window edges.
  assign off     = addr_i - BASE;
  assign hit_o   = (off < WINDOW_BYTES) && (addr_i[1:0] == 2'b00);
  assign wr      = we_i && hit_o;
  assign ctrl_wr = wr && (off == OFF_CTRL);
  assign done_wr = wr && (off == OFF_DONE);
  assign clr     = ctrl_wr && wdata_i[CTRL_CLEAR_BIT];
  assign run     = (state == RUN);
  assign done_o  = (state == FROZEN);
  assign unused_wdata = ^wdata_i[31:2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= AUTO_START ? RUN : IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (done_wr) state_nxt = FROZEN;
        else if (ctrl_wr && wdata_i[CTRL_RUN_BIT]) state_nxt = RUN;
      end
      RUN: begin
        if (done_wr) state_nxt = FROZEN;
        else if (ctrl_wr && !wdata_i[CTRL_RUN_BIT]) state_nxt = IDLE;
      end
      FROZEN: begin
        if (clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  perf_ctr #(.WIDTH(64), .SATURATE(1'b0)) u_cycle (
    .clk(clk), .reset(reset), .en(run), .clr(clr), .inc(1'b1),
    .cnt(cycle_cnt), .sat(sat_vec[0])
  );
  perf_ctr #(.WIDTH(64), .SATURATE(1'b0)) u_instret (
    .clk(clk), .reset(reset), .en(run), .clr(clr), .inc(instret_i),
    .cnt(instret_cnt), .sat(sat_vec[1])
  );
  perf_ctr #(.WIDTH(32), .SATURATE(1'b1)) u_branch (
    .clk(clk), .reset(reset), .en(run), .clr(clr), .inc(branch_e_i),
    .cnt(branch_cnt), .sat(sat_vec[2])
  );
  perf_ctr #(.WIDTH(32), .SATURATE(1'b1)) u_mispred (
    .clk(clk), .reset(reset), .en(run), .clr(clr), .inc(branch_e_i && flush_d_i),
    .cnt(mispred_cnt), .sat(sat_vec[3])
  );
  perf_ctr #(.WIDTH(32), .SATURATE(1'b1)) u_stall (
    .clk(clk), .reset(reset), .en(run), .clr(clr), .inc(stall_f_i),
    .cnt(stall_cnt), .sat(sat_vec[4])
  );
  perf_ctr #(.WIDTH(32), .SATURATE(1'b1)) u_flush (
    .clk(clk), .reset(reset), .en(run), .clr(clr), .inc(flush_d_i || flush_e_i),
    .cnt(flush_cnt), .sat(sat_vec[5])
  );

  assign sat_any = |sat_vec;

  // Reading a LO word freezes the matching HI word so LO-then-HI gives one coherent value.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cycle_hi_snap   <= '0;
      instret_hi_snap <= '0;
    end else if (re_i && hit_o) begin
      if (off == OFF_CYCLE_LO)   cycle_hi_snap   <= cycle_cnt[63:32];
      if (off == OFF_INSTRET_LO) instret_hi_snap <= instret_cnt[63:32];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:       rd_mux = {31'd0, run};
      OFF_STATUS:     rd_mux = {29'd0, sat_any, state};
      OFF_CYCLE_LO:   rd_mux = cycle_cnt[31:0];
      OFF_CYCLE_HI:   rd_mux = cycle_hi_snap;
      OFF_INSTRET_LO: rd_mux = instret_cnt[31:0];
      OFF_INSTRET_HI: rd_mux = instret_hi_snap;
      OFF_BRANCH:     rd_mux = branch_cnt;
      OFF_MISPRED:    rd_mux = mispred_cnt;
      OFF_STALL:      rd_mux = stall_cnt;
      OFF_FLUSH:      rd_mux = flush_cnt;
      default:        rd_mux = '0;
    endcase
  end

  assign rdata_o = hit_o ? rd_mux : 32'd0;

endmodule

// File: tb/tb_perf_counter_mmio.sv
// tb/tb_perf_counter_mmio.sv - self-checking bench for perf_counter_mmio against a behavioural model
module tb_perf_counter_mmio;

  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        clk, reset;
  logic [31:0] addr, wdata;
  logic        we, re, instret, branch, flush_d, flush_e, stall;
  logic [31:0] rdata, rdata0;
  logic        hit, hit0, done, done0;

  int n_checks = 0;
  int n_err    = 0;

  perf_counter_mmio #(.BASE(BASE), .AUTO_START(1'b1)) dut (
    .clk(clk), .reset(reset), .addr_i(addr), .wdata_i(wdata), .we_i(we), .re_i(re),
    .rdata_o(rdata), .hit_o(hit), .instret_i(instret), .branch_e_i(branch),
    .flush_d_i(flush_d), .flush_e_i(flush_e), .stall_f_i(stall), .done_o(done)
  );

  perf_counter_mmio #(.BASE(BASE), .AUTO_START(1'b0)) dut0 (
    .clk(clk), .reset(reset), .addr_i(addr), .wdata_i(wdata), .we_i(we), .re_i(re),
    .rdata_o(rdata0), .hit_o(hit0), .instret_i(instret), .branch_e_i(branch),
    .flush_d_i(flush_d), .flush_e_i(flush_e), .stall_f_i(stall), .done_o(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of the AUTO_START=1 instance: 0 idle, 1 run, 2 frozen.
  int          m_state;
  logic [63:0] m_cycle, m_instret;
  logic [31:0] m_branch, m_mispred, m_stall, m_flush, m_snap_c, m_snap_i;
  bit          started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic ev);
    if (ev && v != 32'hFFFF_FFFF) return v + 32'd1;
    return v;
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (a >= BASE) && (o < 32'd44) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic sat;
    if (!m_hit(a)) return 32'd0;
    sat = (m_branch == 32'hFFFF_FFFF) || (m_mispred == 32'hFFFF_FFFF) ||
          (m_stall == 32'hFFFF_FFFF) || (m_flush == 32'hFFFF_FFFF);
    case (a - BASE)
      32'd0:   return (m_state == 1) ? 32'd1 : 32'd0;
      32'd4:   return (sat ? 32'd4 : 32'd0) + 32'(m_state);
      32'd8:   return m_cycle[31:0];
      32'd12:  return m_snap_c;
      32'd16:  return m_instret[31:0];
      32'd20:  return m_snap_i;
      32'd24:  return m_branch;
      32'd28:  return m_mispred;
      32'd32:  return m_stall;
      32'd36:  return m_flush;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_zero();
    m_cycle = 0; m_instret = 0; m_branch = 0; m_mispred = 0;
    m_stall = 0; m_flush = 0; m_snap_c = 0; m_snap_i = 0;
  endtask

  always @(posedge clk) begin : model_p
    logic [31:0] o;
    logic        h;
    int          prev;
    if (!reset) begin
      m_zero();
      m_state = 1;
    end else begin
      o = addr - BASE;
      h = m_hit(addr);
      if (re && h && o == 32'd8)  m_snap_c = m_cycle[63:32];
      if (re && h && o == 32'd16) m_snap_i = m_instret[63:32];
      prev = m_state;
      if (prev == 1) begin
        m_cycle   = m_cycle + 64'd1;
        m_instret = m_instret + (instret ? 64'd1 : 64'd0);
        m_branch  = sat_inc(m_branch, branch);
        m_mispred = sat_inc(m_mispred, branch & flush_d);
        m_stall   = sat_inc(m_stall, stall);
        m_flush   = sat_inc(m_flush, flush_d | flush_e);
      end
      if (we && h && o == 32'd0) begin
        if (wdata[1]) m_zero();
        if (prev == 2) begin
          if (wdata[1]) m_state = 0;
        end else begin
          m_state = wdata[0] ? 1 : 0;
        end
      end else if (we && h && o == 32'd40) begin
        m_state = 2;
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rdata", rdata, m_read(addr));
      chk("hit", {31'd0, hit}, {31'd0, m_hit(addr)});
      chk("done", {31'd0, done}, (m_state == 2) ? 32'd1 : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] o, input logic [31:0] d);
    addr = BASE + o; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [31:0] o, input logic [31:0] exp, input string nm, input bit which);
    addr = BASE + o; re = 1'b1;
    @(negedge clk);
    chk(nm, which ? rdata0 : rdata, exp);
    tick();
    re = 1'b0; addr = 32'd0;
  endtask

  task automatic set_ev(input logic v);
    instret = v; branch = v; flush_d = v; flush_e = v; stall = v;
  endtask

  initial begin
    reset = 1'b0; addr = 0; wdata = 0; we = 0; re = 0;
    set_ev(1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Auto-start run: ten counted cycles.
    repeat (10) tick();
    rd(32'h08, 32'd10, "cycle_lo_10", 1'b0);
    rd(32'h0C, 32'd0, "cycle_hi_0", 1'b0);
    rd(32'h04, 32'd1, "status_run", 1'b0);
    @(negedge clk);
    chk("done_low", {31'd0, done}, 32'd0);
    tick();

    for (int k = 0; k < 7; k++) begin
      instret = 1'b1; branch = (k < 3); flush_d = (k == 0); stall = (k < 2);
      tick();
    end
    set_ev(1'b0);
    rd(32'h10, 32'd7, "instret_7", 1'b0);
    rd(32'h14, 32'd0, "instret_hi", 1'b0);
    rd(32'h18, 32'd3, "branch_3", 1'b0);
    rd(32'h1C, 32'd1, "mispred_1", 1'b0);
    rd(32'h20, 32'd2, "stall_2", 1'b0);
    rd(32'h24, 32'd1, "flush_1", 1'b0);

    // Freeze with a coincident retire, then hammer events while frozen.
    instret = 1'b1;
    wr(32'h28, 32'hDEAD_BEEF);
    instret = 1'b0;
    @(negedge clk);
    chk("done_high", {31'd0, done}, 32'd1);
    set_ev(1'b1);
    repeat (20) tick();
    set_ev(1'b0);
    rd(32'h10, 32'd8, "instret_frozen", 1'b0);
    rd(32'h18, 32'd3, "branch_frozen", 1'b0);
    wr(32'h00, 32'h1);
    rd(32'h04, 32'd2, "frozen_ignores_run", 1'b0);
    wr(32'h00, 32'h3);
    rd(32'h04, 32'd0, "status_idle", 1'b0);
    rd(32'h08, 32'd0, "cycle_cleared", 1'b0);
    rd(32'h10, 32'd0, "instret_cleared", 1'b0);

    // RUN entry with a coincident retire, then 64-bit wrap via preload.
    instret = 1'b1;
    wr(32'h00, 32'h1);
    instret = 1'b0;
    rd(32'h10, 32'd0, "instret_run_entry", 1'b0);
    @(negedge clk);
    #1;
    force dut.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFF;
    m_cycle = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.u_cycle.cnt_q;
    tick();
    rd(32'h08, 32'd0, "wrap_lo", 1'b0);
    rd(32'h0C, 32'd1, "wrap_hi", 1'b0);

    @(negedge clk);
    #1;
    force dut.u_branch.cnt_q = 32'hFFFF_FFFE;
    m_branch = 32'hFFFF_FFFE;
    #1 release dut.u_branch.cnt_q;
    tick();
    branch = 1'b1;
    repeat (2) tick();
    branch = 1'b0;
    rd(32'h18, 32'hFFFF_FFFF, "branch_sat", 1'b0);
    rd(32'h04, 32'd5, "status_sat", 1'b0);

    // Clear beats a coincident retire; out-of-window and misaligned accesses.
    instret = 1'b1;
    wr(32'h00, 32'h3);
    instret = 1'b0;
    rd(32'h10, 32'd0, "clear_wins", 1'b0);
    rd(32'h04, 32'd1, "status_sat_cleared", 1'b0);
    addr = BASE + 32'h2C; re = 1'b1;
    @(negedge clk);
    chk("oob_rdata", rdata, 32'd0);
    chk("oob_hit", {31'd0, hit}, 32'd0);
    tick();
    addr = BASE + 32'h09;
    @(negedge clk);
    chk("misaligned_hit", {31'd0, hit}, 32'd0);
    tick();
    re = 1'b0; addr = 0;
    wr(32'h04, 32'h2);
    rd(32'h04, 32'd1, "ro_store_ignored", 1'b0);
    stall = 1'b1;
    wr(32'h00, 32'h0);
    stall = 1'b0;
    rd(32'h20, 32'd1, "stall_on_idle_edge", 1'b0);
    rd(32'h04, 32'd0, "status_idle2", 1'b0);

    // Reset mid-run; the AUTO_START=0 instance must come up idle and quiet.
    wr(32'h00, 32'h1);
    set_ev(1'b1);
    repeat (5) tick();
    set_ev(1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int o = 0; o < 40; o += 4) rd(32'(o), 32'd0, "dut0_reset_read", 1'b1);
    set_ev(1'b1);
    repeat (5) tick();
    rd(32'h08, 32'd0, "dut0_idle_cycle", 1'b1);
    rd(32'h10, 32'd0, "dut0_idle_instret", 1'b1);
    set_ev(1'b0);
    instret = 1'b1;
    wr(32'h00, 32'h1);
    instret = 1'b0;
    repeat (3) tick();
    rd(32'h08, 32'd3, "dut0_cycle_3", 1'b1);
    rd(32'h10, 32'd0, "dut0_instret_entry", 1'b1);
    rd(32'h04, 32'd1, "dut0_status_run", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/perf_counter_mmio.md
# perf_counter_mmio

Memory-mapped hardware performance-counter unit for the RV32I pipelined core. It samples the hazard-unit and pipeline event strobes every cycle and counts cycles, retired instructions, branches, mispredictions, stall cycles and flushes. Software reads the counts with ordinary loads, making CPI measurement possible on silicon and in firmware. It sits on the data-memory bus as an address-decoded responder alongside data memory.

## Interface
Parameters:
- BASE, 32'h0000_4000, byte base address of the register window (44 bytes, 11 words).
- AUTO_START, 1'b1, state after reset: 1 = RUN, 0 = IDLE.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-low; clock clk.
- addr_i  in  32  data-bus byte address (ALUResultM).
- wdata_i  in  32  store data (WriteDataM).
- we_i  in  1  store strobe (MemWriteM).
- re_i  in  1  load strobe.
- rdata_o  out  32  read data, combinational.
- hit_o  out  1  address falls in window and is word-aligned, combinational.
- instret_i  in  1  a valid, non-bubble instruction retires in WB this cycle.
- branch_e_i  in  1  a branch resolves in EX this cycle.
- flush_d_i  in  1  hazard-unit FlushD.
- flush_e_i  in  1  hazard-unit FlushE.
- stall_f_i  in  1  hazard-unit StallF.
- done_o  out  1  high while in state FROZEN.

## Operation
Register map (offset from BASE):
- 0x00 CTRL (RW): bit0 = run, bit1 = clear (self-clearing, reads 0).
- 0x04 STATUS (RO): [1:0] = state, bit2 = a 32-bit counter has saturated.
- 0x08 CYCLE_LO (RO) and 0x0C CYCLE_HI (RO, snapshot).
- 0x10 INSTRET_LO (RO) and 0x14 INSTRET_HI (RO, snapshot).
- 0x18 BRANCH, 0x1C MISPRED, 0x20 STALL, 0x24 FLUSH (RO, 32-bit).
- 0x28 DONE (WO): any store moves the unit to FROZEN.

Counting rules:
- CYCLE and INSTRET are 64-bit counters that wrap.
- The four 32-bit counters saturate at 32'hFFFF_FFFF.
- Increments happen only while the state is RUN:
  - CYCLE counts every cycle.
  - INSTRET counts when instret_i is high.
  - BRANCH counts when branch_e_i is high.
  - MISPRED counts when branch_e_i & flush_d_i.
  - STALL counts when stall_f_i is high.
  - FLUSH counts when flush_d_i | flush_e_i.

State machine (states: IDLE = 0, RUN = 1, FROZEN = 2):
- IDLE → RUN on a CTRL store with bit0 = 1.
- RUN → IDLE on a CTRL store with bit0 = 0. Counts are held.
- RUN or IDLE → FROZEN on any DONE store.
- FROZEN exits only on a CTRL store with bit1 = 1. The next state is IDLE; a CTRL bit0 = 1 in the same store is ignored.
- A clear (CTRL bit1 = 1) in any state zeroes all counters, both snapshots and the saturation flag.

Access rules:
- Stores to RO offsets and unmapped offsets are ignored.
- Loads from unmapped offsets or misaligned addresses return 0, with hit_o = 0.
- When addr_i is outside the window, rdata_o = 0.

## Timing
- Reset (reset = 0 at a posedge) sets:
  - all counters, snapshots and the saturation flag to 0;
  - the state to RUN if AUTO_START = 1, otherwise IDLE;
  - done_o = 0.
- Register writes and event increments take effect at the posedge and are visible on rdata_o the following cycle. Latency is 1 cycle.
- Event gating uses the state before the edge. An event coincident with a RUN-entering CTRL store is not counted. An event coincident with a DONE or IDLE-entering store is counted.
- A clear coincident with any event wins: the counters read 0 next cycle.
- Snapshot rule: a load (re_i) of CYCLE_LO returns the live low word and latches the live high word into the CYCLE_HI snapshot at the same edge. INSTRET_LO/INSTRET_HI behave the same way. Reading a _HI offset returns the snapshot, which gives a consistent 64-bit pair across LO-then-HI reads.
- Wrap: CYCLE = 64'h0000_0000_FFFF_FFFF plus one cycle in RUN gives LO = 0, HI = 1.
- Saturation: a 32-bit counter at 32'hFFFF_FFFF stays there, and STATUS bit2 is set.

## Structure
- Package perf_pkg holds the offset localparams (OFF_CTRL … OFF_DONE), the state enum perf_state_t {IDLE, RUN, FROZEN}, and CTRL bit positions.
- Sub-module perf_ctr has parameters WIDTH and SATURATE, and inputs en, clr, inc. It outputs cnt and sat.
- The top instantiates six perf_ctr, the FSM, the address decode, the snapshot registers and the read mux.

## Test plan
- Reset with AUTO_START = 1, then 10 RUN cycles → CYCLE_LO = 10, CYCLE_HI = 0, STATUS[1:0] = 1, done_o = 0.
- Pulse instret_i 7 times, branch_e_i 3 times (one of them with flush_d_i), and stall_f_i for 2 cycles → INSTRET = 7, BRANCH = 3, MISPRED = 1, STALL = 2, FLUSH = 1.
- Store to BASE+0x28 → done_o = 1 next cycle; the counters stay fixed over 20 further cycles of events; a CTRL store of 32'h2 → state IDLE and all counters read 0.
- Preload CYCLE = 64'hFFFF_FFFF via a force, then run 1 cycle → load BASE+0x08 returns 0, and a following load of BASE+0x0C returns 1 even though the counter kept running.
- Clear store coincident with instret_i → INSTRET reads 0. A load of BASE+0x2C → rdata_o = 0 and hit_o = 0.
- Assert reset mid-RUN with AUTO_START = 0 → all reads return 0, state IDLE, and no counting until a CTRL store of 32'h1.
